bp_cce_alu_wb: RTL and testbench
================================

BP_CCE_ALU_WB -- requirements
Module: bp_cce_alu_wb

Interface
REQ-001 SHALL have parameter width_p, default 16: arithmetic/GPR data width in bits, must match the CCE ALU operand width.
REQ-002 SHALL have parameter gpr_els_p, default 8: number of GPRs, power of two, at least 2.
REQ-003 SHALL have derived width lg_gpr_els_lp = log2(gpr_els_p), used in the port widths below.
REQ-004 SHALL have port clk_i  input  1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_i  input  1: reset, asynchronous and active-high.
REQ-006 SHALL have port src_a_sel_i  input  lg_gpr_els_lp: GPR index for ALU operand A.
REQ-007 SHALL have port src_b_sel_i  input  lg_gpr_els_lp: GPR index for ALU operand B.
REQ-008 SHALL have port opd_a_o  output  width_p: operand A value driven to the ALU.
REQ-009 SHALL have port opd_b_o  output  width_p: operand B value driven to the ALU.
REQ-010 SHALL have port res_v_i  input  1: ALU result valid.
REQ-011 SHALL have port res_i  input  width_p: ALU result.
REQ-012 SHALL have port dst_sel_i  input  lg_gpr_els_lp: destination GPR index for the result.
REQ-013 SHALL have port res_ready_and_o  output  1: writeback can accept a result this cycle.
REQ-014 SHALL have port stall_i  input  1: blocks the GPR commit of the pending result.
REQ-015 SHALL have port wb_v_o  output  1: a result is pending commit.
REQ-016 SHALL have port zero_o  output  1: the last committed result was zero.

Function
REQ-017 SHALL hold a one-entry writeback register: wb_v_r, wb_data_r (width_p), wb_dst_r (lg_gpr_els_lp).
REQ-018 SHALL hold a GPR array of gpr_els_p entries of width_p bits.
REQ-019 SHALL drive res_ready_and_o = ~wb_v_r | ~stall_i, combinationally, with no dependence on res_v_i.
REQ-020 SHALL accept a result when res_v_i & res_ready_and_o, capturing res_i and dst_sel_i into the writeback register at the next edge with wb_v_r = 1.
REQ-021 SHALL commit wb_data_r to GPR[wb_dst_r] and update zero_o = (wb_data_r == 0) at the edge where wb_v_r & ~stall_i.
REQ-022 SHALL clear wb_v_r after a commit when no result is accepted in the same cycle.
REQ-023 SHALL perform commit and accept in the same cycle, keeping wb_v_r = 1 and holding the new result (back-to-back throughput of one result per cycle).
REQ-024 SHALL hold wb_v_r, wb_data_r, wb_dst_r, the GPR array and zero_o unchanged while stall_i = 1 and wb_v_r = 1; an offered res_v_i is not accepted in that state.
REQ-025 SHALL let res_v_i be accepted when wb_v_r = 0 regardless of stall_i; stall_i blocks only the commit.
REQ-026 SHALL read operands combinationally: opd_x_o = wb_data_r when wb_v_r and src_x_sel_i == wb_dst_r, else GPR[src_x_sel_i] (forwarding, zero-cycle bypass of the pending result).
REQ-027 SHALL apply forwarding independently to A and B; both may forward when both select wb_dst_r.
REQ-028 SHALL NOT forward the incoming res_i combinationally; a result becomes visible one cycle after acceptance.
REQ-029 SHALL write only the GPR addressed by wb_dst_r; same-destination back-to-back results leave the newest value.
REQ-030 SHALL drive wb_v_o = wb_v_r.
REQ-031 SHALL have no other timing of its own: a result appears in the GPR array one edge after acceptance if unstalled.

Reset
REQ-032 SHALL, on reset_i asserted (asynchronously), clear wb_v_r, wb_data_r, wb_dst_r, all GPRs and zero_o to 0.
REQ-033 SHALL drop any pending result on reset mid-operation and leave it uncommitted.
REQ-034 SHALL hold res_ready_and_o = 1, wb_v_o = 0 and opd_a_o = opd_b_o = 0 while in reset.

Verification
REQ-035 SHALL be covered by a directed reset test: assert reset_i mid-cycle with a pending write of 0x1234 to GPR3 -> immediately wb_v_o = 0; after release GPR3 reads 0 and zero_o = 0.
REQ-036 SHALL be covered by a directed accept/commit test: accept 0x00FF to GPR2, stall_i = 0 -> next cycle src_a_sel_i = 2 gives 0x00FF via bypass; the following cycle gives 0x00FF from the array with zero_o = 0.
REQ-037 SHALL be covered by a directed back-to-back test: accept 0x0001 then 0x0002 to GPR5 on consecutive cycles -> res_ready_and_o stays 1; after both commit GPR5 = 0x0002.
REQ-038 SHALL be covered by a directed stall test: pending 0x0000 to GPR1 with stall_i = 1 for 3 cycles and res_v_i held at 0xBEEF -> res_ready_and_o = 0, GPR1 unchanged, opd_b_o (sel 1) = 0x0000 via bypass; on stall release commits and zero_o = 1, and 0xBEEF is accepted that cycle.
REQ-039 SHALL be covered by a directed dual-bypass test: pending 0xA5A5 to GPR7, src_a_sel_i = src_b_sel_i = 7 -> both operands read 0xA5A5; GPR6 is unaffected.

Source files
------------

// File: rtl/bp_cce_alu_wb.sv
// CCE ALU writeback stage: a one-entry result register in front of a small GPR
// file. Operand reads bypass the pending result so that a dependent instruction
// sees the value before it is committed to the array.
module bp_cce_alu_wb #(
    parameter  int width_p       = 16,
    parameter  int gpr_els_p     = 8,
    localparam int lg_gpr_els_lp = $clog2(gpr_els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic [lg_gpr_els_lp-1:0] src_a_sel_i,
    input  logic [lg_gpr_els_lp-1:0] src_b_sel_i,
    output logic [width_p-1:0]       opd_a_o,
    output logic [width_p-1:0]       opd_b_o,

    input  logic                     res_v_i,
    input  logic [width_p-1:0]       res_i,
    input  logic [lg_gpr_els_lp-1:0] dst_sel_i,
    output logic                     res_ready_and_o,

    input  logic                     stall_i,
    output logic                     wb_v_o,
    output logic                     zero_o
);

    logic                     wb_v_q,    wb_v_d;
    logic [width_p-1:0]       wb_data_q, wb_data_d;
    logic [lg_gpr_els_lp-1:0] wb_dst_q,  wb_dst_d;
    logic                     zero_q,    zero_d;
    logic [width_p-1:0]       gpr_q [gpr_els_p];
    logic [width_p-1:0]       gpr_d [gpr_els_p];

    logic accept;
    logic commit;

    // The slot frees up whenever its occupant is allowed to commit, so a new
    // result can enter in the same cycle the old one leaves.
    assign res_ready_and_o = ~wb_v_q | ~stall_i;
    assign accept          = res_v_i & res_ready_and_o;
    assign commit          = wb_v_q & ~stall_i;

    assign wb_v_o = wb_v_q;
    assign zero_o = zero_q;

    // Operand read with bypass of the pending (not yet committed) result.
    always_comb begin
        opd_a_o = gpr_q[src_a_sel_i];
        opd_b_o = gpr_q[src_b_sel_i];
        if (wb_v_q && (src_a_sel_i == wb_dst_q)) opd_a_o = wb_data_q;
        if (wb_v_q && (src_b_sel_i == wb_dst_q)) opd_b_o = wb_data_q;
    end

    // Next state: commit the pending result first, then let an accepted
    // result overwrite the slot so back-to-back results keep wb_v set.
    always_comb begin
        wb_v_d    = wb_v_q;
        wb_data_d = wb_data_q;
        wb_dst_d  = wb_dst_q;
        zero_d    = zero_q;
        gpr_d     = gpr_q;
        if (commit) begin
            gpr_d[wb_dst_q] = wb_data_q;
            zero_d          = (wb_data_q == '0);
            wb_v_d          = 1'b0;
        end
        if (accept) begin
            wb_v_d    = 1'b1;
            wb_data_d = res_i;
            wb_dst_d  = dst_sel_i;
        end
    end

    // State registers; reset drops any pending result without committing it.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wb_v_q    <= 1'b0;
            wb_data_q <= '0;
            wb_dst_q  <= '0;
            zero_q    <= 1'b0;
            for (int i = 0; i < gpr_els_p; i++) gpr_q[i] <= '0;
        end else begin
            wb_v_q    <= wb_v_d;
            wb_data_q <= wb_data_d;
            wb_dst_q  <= wb_dst_d;
            zero_q    <= zero_d;
            gpr_q     <= gpr_d;
        end
    end

endmodule

// File: tb/tb_bp_cce_alu_wb.sv
// Directed bench for bp_cce_alu_wb: a per-cycle vector table (inputs applied
// after the falling edge, outputs checked before the next rising edge) plus a
// hand-written mid-cycle reset sequence.
module tb_bp_cce_alu_wb;

    localparam int W = 16;
    localparam int S = 3;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic [S-1:0] src_a_sel_i, src_b_sel_i, dst_sel_i;
    logic [W-1:0] opd_a_o, opd_b_o, res_i;
    logic         res_v_i, res_ready_and_o, stall_i, wb_v_o, zero_o;

    int n_pass  = 0;
    int n_total = 0;

    bp_cce_alu_wb #(.width_p(W), .gpr_els_p(8)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .src_a_sel_i    (src_a_sel_i),
        .src_b_sel_i    (src_b_sel_i),
        .opd_a_o        (opd_a_o),
        .opd_b_o        (opd_b_o),
        .res_v_i        (res_v_i),
        .res_i          (res_i),
        .dst_sel_i      (dst_sel_i),
        .res_ready_and_o(res_ready_and_o),
        .stall_i        (stall_i),
        .wb_v_o         (wb_v_o),
        .zero_o         (zero_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [S-1:0] sa, sb;
        logic         rv;
        logic [W-1:0] res;
        logic [S-1:0] dst;
        logic         stall;
        logic         e_rdy, e_wbv, e_zero;
        logic [W-1:0] e_a, e_b;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [S-1:0] sa, sb, input logic rv, input logic [W-1:0] res,
                       input logic [S-1:0] dst, input logic stall,
                       input logic e_rdy, e_wbv, e_zero, input logic [W-1:0] e_a, e_b);
        vec_t v;
        v.sa = sa; v.sb = sb; v.rv = rv; v.res = res; v.dst = dst; v.stall = stall;
        v.e_rdy = e_rdy; v.e_wbv = e_wbv; v.e_zero = e_zero; v.e_a = e_a; v.e_b = e_b;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    initial begin
        //   sa  sb  rv  res      dst stl  rdy wbv zero a        b
        // accept 0x00FF -> GPR2; bypass next cycle, array the cycle after
        add(0,  0,  0, 16'h0000, 0, 0,   1,  0,  0,  16'h0000, 16'h0000);
        add(2,  2,  1, 16'h00FF, 2, 0,   1,  0,  0,  16'h0000, 16'h0000);
        add(2,  3,  0, 16'h0000, 0, 0,   1,  1,  0,  16'h00FF, 16'h0000);
        add(2,  2,  0, 16'h0000, 0, 0,   1,  0,  0,  16'h00FF, 16'h00FF);
        // back-to-back 0x0001 then 0x0002 -> GPR5
        add(5,  0,  1, 16'h0001, 5, 0,   1,  0,  0,  16'h0000, 16'h0000);
        add(5,  2,  1, 16'h0002, 5, 0,   1,  1,  0,  16'h0001, 16'h00FF);
        add(5,  0,  0, 16'h0000, 0, 0,   1,  1,  0,  16'h0002, 16'h0000);
        add(5,  0,  0, 16'h0000, 0, 0,   1,  0,  0,  16'h0002, 16'h0000);
        // pending 0x0000 -> GPR1 stalled 3 cycles while 0xBEEF -> GPR4 is offered
        add(0,  1,  1, 16'h0000, 1, 0,   1,  0,  0,  16'h0000, 16'h0000);
        add(1,  1,  1, 16'hBEEF, 4, 1,   0,  1,  0,  16'h0000, 16'h0000);
        add(4,  1,  1, 16'hBEEF, 4, 1,   0,  1,  0,  16'h0000, 16'h0000);
        add(4,  1,  1, 16'hBEEF, 4, 1,   0,  1,  0,  16'h0000, 16'h0000);
        add(4,  1,  1, 16'hBEEF, 4, 0,   1,  1,  0,  16'h0000, 16'h0000);
        add(4,  1,  0, 16'h0000, 0, 0,   1,  1,  1,  16'hBEEF, 16'h0000);
        add(4,  2,  0, 16'h0000, 0, 0,   1,  0,  0,  16'hBEEF, 16'h00FF);
        // accept under stall with empty slot, then dual bypass of 0xA5A5 -> GPR7
        add(7,  6,  1, 16'hA5A5, 7, 1,   1,  0,  0,  16'h0000, 16'h0000);
        add(7,  7,  0, 16'h0000, 0, 1,   0,  1,  0,  16'hA5A5, 16'hA5A5);
        add(7,  6,  0, 16'h0000, 0, 0,   1,  1,  0,  16'hA5A5, 16'h0000);
        add(7,  6,  0, 16'h0000, 0, 0,   1,  0,  0,  16'hA5A5, 16'h0000);
        // commit a zero to GPR0 so zero_o is set going into the reset test
        add(0,  4,  1, 16'h0000, 0, 0,   1,  0,  0,  16'h0000, 16'hBEEF);
        add(0,  4,  0, 16'h0000, 0, 0,   1,  1,  0,  16'h0000, 16'hBEEF);
        add(0,  4,  0, 16'h0000, 0, 0,   1,  0,  1,  16'h0000, 16'hBEEF);

        reset_i = 1'b1; res_v_i = 1'b0; res_i = '0; dst_sel_i = '0; stall_i = 1'b0;
        src_a_sel_i = 3'd2; src_b_sel_i = 3'd5;
        #7;
        chk("rst_ready", {15'd0, res_ready_and_o}, 16'd1);
        chk("rst_wbv",   {15'd0, wb_v_o},          16'd0);
        chk("rst_zero",  {15'd0, zero_o},          16'd0);
        chk("rst_opd_a", opd_a_o, 16'h0000);
        chk("rst_opd_b", opd_b_o, 16'h0000);
        @(negedge clk_i);
        reset_i = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk_i);
            src_a_sel_i = vecs[i].sa; src_b_sel_i = vecs[i].sb;
            res_v_i = vecs[i].rv; res_i = vecs[i].res; dst_sel_i = vecs[i].dst;
            stall_i = vecs[i].stall;
            #2;
            chk($sformatf("v%0d_ready", i), {15'd0, res_ready_and_o}, {15'd0, vecs[i].e_rdy});
            chk($sformatf("v%0d_wbv",   i), {15'd0, wb_v_o},          {15'd0, vecs[i].e_wbv});
            chk($sformatf("v%0d_zero",  i), {15'd0, zero_o},          {15'd0, vecs[i].e_zero});
            chk($sformatf("v%0d_opd_a", i), opd_a_o, vecs[i].e_a);
            chk($sformatf("v%0d_opd_b", i), opd_b_o, vecs[i].e_b);
        end

        // mid-cycle reset with 0x1234 pending for GPR3
        @(negedge clk_i);
        res_v_i = 1'b1; res_i = 16'h1234; dst_sel_i = 3'd3; stall_i = 1'b0;
        @(negedge clk_i);
        res_v_i = 1'b0; res_i = '0; stall_i = 1'b1;
        src_a_sel_i = 3'd3; src_b_sel_i = 3'd7;
        #1;
        chk("pre_rst_wbv",   {15'd0, wb_v_o}, 16'd1);
        chk("pre_rst_opd_a", opd_a_o, 16'h1234);
        chk("pre_rst_zero",  {15'd0, zero_o}, 16'd1);
        #2;
        reset_i = 1'b1;
        #1;
        chk("mid_rst_wbv",   {15'd0, wb_v_o},          16'd0);
        chk("mid_rst_ready", {15'd0, res_ready_and_o}, 16'd1);
        chk("mid_rst_opd_a", opd_a_o, 16'h0000);
        chk("mid_rst_opd_b", opd_b_o, 16'h0000);
        chk("mid_rst_zero",  {15'd0, zero_o},          16'd0);
        @(negedge clk_i);
        reset_i = 1'b0; stall_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        chk("post_rst_gpr3", opd_a_o, 16'h0000);
        chk("post_rst_gpr7", opd_b_o, 16'h0000);
        chk("post_rst_zero", {15'd0, zero_o}, 16'd0);
        chk("post_rst_wbv",  {15'd0, wb_v_o}, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
